vga_rx_tracker: RTL and testbench
=================================

Name: vga_rx_tracker

Overview:
- Receiver end of the VGA pixel stream. Samples the sync, blank and RGB outputs on the pixel clock, the same clock that drives ControllerSync.
- Recovers pixel coordinates, checks frame geometry, and locks to the stream.
- Reports per frame the bounding box of all pixels matching a key colour.
- Used as an on-chip self-checker and as the position sensor for the guessing game.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- KEY_RGB, 24'hFF0000, colour to track ({R,G,B})
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  pixel clock (25 MHz, clockVGA)
- reset  in  1  asynchronous, active-low reset
- vga_hs  in  1  horizontal sync, active-low
- vga_vs  in  1  vertical sync, active-low
- vga_blank_n  in  1  high during active video
- red  in  8  pixel red
- green  in  8  pixel green
- blue  in  8  pixel blue
- pix_x  out  10  recovered column of the current active pixel
- pix_y  out  10  recovered row of the current active pixel
- locked  out  1  stream geometry verified
- geom_err  out  1  one-cycle pulse on a line-length or line-count mismatch
- frame_done  out  1  one-cycle pulse; bounding-box outputs updated
- obj_found  out  1  at least one key pixel in the last complete frame
- obj_x_min, obj_x_max, obj_y_min, obj_y_max  out  10 each  bounding box of the last frame

Behaviour:
- Input registering
  - All inputs are registered once. Edges are derived from the registered value versus a one-cycle-delayed copy.
  - Output latency is 1 cycle from sample, plus 1 cycle from edge detection.
- Coordinate recovery
  - x_cnt clears on the blank_n rising edge and increments each cycle while blank_n is high.
  - On the blank_n falling edge:
    - the final x_cnt is checked against H_ACTIVE;
    - y_cnt increments.
  - On the vga_vs falling edge: y_cnt is checked against V_ACTIVE, then cleared.
  - Both counters saturate at 1023; a saturated counter counts as a mismatch.
  - pix_x and pix_y equal x_cnt and y_cnt during active video and hold their last value otherwise.
- Lock FSM, states UNLOCKED, WAIT_VS, MEASURE, LOCKED
  - UNLOCKED goes to WAIT_VS immediately.
  - WAIT_VS goes to MEASURE on a vs falling edge; good_frames is cleared.
  - MEASURE: every line and the frame must match. On the vs falling edge with no error, good_frames increments. When good_frames reaches LOCK_FRAMES, go to LOCKED.
  - In MEASURE or LOCKED, any mismatch pulses geom_err and goes to WAIT_VS.
  - locked is 1 only in LOCKED.
- Bounding box
  - An accumulator updates on active pixels with {red,green,blue}==KEY_RGB, using min/max compare on x_cnt and y_cnt.
  - A hit flag marks any match.
  - Accumulators initialise to min=1023, max=0, hit=0.
- Frame end (vs falling edge with y_cnt==V_ACTIVE and no line error in the frame)
  - Latch the accumulators into the outputs and pulse frame_done.
  - If hit==0: obj_found=0 and all four bbox outputs are 0.
  - Re-initialise the accumulators in the same cycle. A key pixel on that exact cycle cannot occur, since blanking is active.
- Bad frame: accumulators re-initialise, outputs hold, no frame_done.
- frame_done is emitted in MEASURE and LOCKED only. geom_err and frame_done are mutually exclusive.
- Single-pixel object: min==max on both axes.
- Reset (asynchronous, any time)
  - All outputs 0, state UNLOCKED, counters 0, accumulators initialised.
  - Reset mid-frame discards the partial frame; lock re-acquisition needs a fresh vs edge plus LOCK_FRAMES frames.

Decomposition:
- Package vga_rx_pkg:
  - state enum (UNLOCKED, WAIT_VS, MEASURE, LOCKED);
  - coord_t (logic [9:0]);
  - COORD_MAX = 10'd1023.
- Sub-module sync_edge_det: registered rise/fall detector, instantiated three times (hs, vs, blank_n).
- All remaining logic (counters, FSM, bbox) lives in vga_rx_tracker.

Test Plan:
1. Standard 640x480 timing for 3 frames, no key colour -> locked=1 after the vs edge ending frame 2; frame_done pulses at the end of each locked/measure frame; obj_found=0; bbox=0.
2. Red 20x10 square at x=100..119, y=200..209 -> frame_done with obj_found=1, x_min=100, x_max=119, y_min=200, y_max=209.
3. Single key pixel at (639,479) -> bbox min=max=639 on x and min=max=479 on y.
4. One line shortened to 639 pixels while locked -> geom_err pulses 1 cycle at that blank_n fall; locked=0; no frame_done for that frame; lock returns after 2 good frames.
5. Assert reset mid-frame while locked -> all outputs 0 immediately; after release, locked is reached only after one vs edge plus 2 good frames.
6. Frame with 481 active lines -> geom_err at the vs falling edge; outputs keep the previous frame's bbox.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared types for the VGA receive-side tracker.
// State encoding, coordinate type and saturating helper.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    WAIT_VS,
    MEASURE,
    LOCKED
  } state_t;

  typedef logic [9:0] coord_t;

  localparam coord_t COORD_MAX = 10'd1023;

  function automatic coord_t sat_inc(coord_t v);
    return (v == COORD_MAX) ? COORD_MAX : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_rx_tracker_sync_edge_det.sv
// Registers one input and flags its rising/falling edges
// against a one-cycle-delayed copy.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  // sample the input, keep one cycle of history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/vga_rx_tracker.sv
// VGA stream receiver: coordinate recovery, geometry lock
// and per-frame bounding box of key-coloured pixels.
module vga_rx_tracker
  import vga_rx_pkg::*;
#(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [23:0] KEY_RGB     = 24'hFF0000,
  parameter int          LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output coord_t     pix_x,
  output coord_t     pix_y,
  output logic       locked,
  output logic       geom_err,
  output logic       frame_done,
  output logic       obj_found,
  output coord_t     obj_x_min,
  output coord_t     obj_x_max,
  output coord_t     obj_y_min,
  output coord_t     obj_y_max
);

  localparam coord_t     H_END  = coord_t'(H_ACTIVE);
  localparam coord_t     V_END  = coord_t'(V_ACTIVE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_q, hs_rise, hs_fall;
  logic        vs_q, vs_rise, vs_fall;
  logic        blank_q, blank_rise, blank_fall;
  logic        unused_edges;
  logic [23:0] rgb_q;

  state_t      state;
  logic [3:0]  good_frames;
  coord_t      x_cnt, y_cnt, x_cur;
  logic        line_bad;
  logic        line_mis, frame_mis, mis;
  logic        frame_ok, tracking, key_hit;

  coord_t      acc_x_min, acc_x_max;
  coord_t      acc_y_min, acc_y_max;
  logic        acc_hit;

  sync_edge_det u_hs (
    .clk(clk), .reset(reset), .d(vga_hs),
    .q(hs_q), .rise(hs_rise), .fall(hs_fall)
  );

  sync_edge_det u_vs (
    .clk(clk), .reset(reset), .d(vga_vs),
    .q(vs_q), .rise(vs_rise), .fall(vs_fall)
  );

  sync_edge_det u_blank (
    .clk(clk), .reset(reset), .d(vga_blank_n),
    .q(blank_q), .rise(blank_rise), .fall(blank_fall)
  );

  // hsync is registered for symmetry but not needed for tracking
  assign unused_edges = ^{hs_q, hs_rise, hs_fall, vs_q, vs_rise};

  // colour sample aligned with the registered blank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_q <= '0;
    else        rgb_q <= {red, green, blue};
  end

  assign x_cur     = blank_rise ? '0 : x_cnt;
  assign key_hit   = blank_q && (rgb_q == KEY_RGB);
  assign line_mis  = blank_fall &&
                     (x_cnt != H_END || x_cnt == COORD_MAX);
  assign frame_mis = vs_fall &&
                     (y_cnt != V_END || y_cnt == COORD_MAX);
  assign mis       = line_mis | frame_mis;
  assign frame_ok  = vs_fall && !mis && !line_bad;
  assign tracking  = (state == MEASURE) || (state == LOCKED);

  // pixel/line counters and the visible coordinate outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      line_bad <= 1'b0;
    end else begin
      if (blank_q) begin
        x_cnt <= sat_inc(x_cur);
        pix_x <= x_cur;
        pix_y <= y_cnt;
      end
      if (vs_fall)         y_cnt <= '0;
      else if (blank_fall) y_cnt <= sat_inc(y_cnt);
      if (vs_fall)         line_bad <= 1'b0;
      else if (line_mis)   line_bad <= 1'b1;
    end
  end

  // lock state machine with registered status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= UNLOCKED;
      good_frames <= '0;
      locked      <= 1'b0;
      geom_err    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      geom_err   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        UNLOCKED: state <= WAIT_VS;
        WAIT_VS: begin
          if (vs_fall) begin
            state       <= MEASURE;
            good_frames <= '0;
          end
        end
        MEASURE: begin
          if (mis) begin
            geom_err <= 1'b1;
            state    <= WAIT_VS;
          end else if (frame_ok) begin
            frame_done  <= 1'b1;
            good_frames <= good_frames + 4'd1;
            if (good_frames + 4'd1 == LOCK_N) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (mis) begin
            geom_err <= 1'b1;
            locked   <= 1'b0;
            state    <= WAIT_VS;
          end else if (frame_ok) begin
            frame_done <= 1'b1;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // bounding-box accumulation and per-frame latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_x_min <= COORD_MAX;
      acc_x_max <= '0;
      acc_y_min <= COORD_MAX;
      acc_y_max <= '0;
      acc_hit   <= 1'b0;
      obj_found <= 1'b0;
      obj_x_min <= '0;
      obj_x_max <= '0;
      obj_y_min <= '0;
      obj_y_max <= '0;
    end else if (vs_fall) begin
      if (frame_ok && tracking) begin
        obj_found <= acc_hit;
        obj_x_min <= acc_hit ? acc_x_min : '0;
        obj_x_max <= acc_hit ? acc_x_max : '0;
        obj_y_min <= acc_hit ? acc_y_min : '0;
        obj_y_max <= acc_hit ? acc_y_max : '0;
      end
      acc_x_min <= COORD_MAX;
      acc_x_max <= '0;
      acc_y_min <= COORD_MAX;
      acc_y_max <= '0;
      acc_hit   <= 1'b0;
    end else if (key_hit) begin
      if (x_cur < acc_x_min) acc_x_min <= x_cur;
      if (x_cur > acc_x_max) acc_x_max <= x_cur;
      if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
      if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
      acc_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_rx_tracker.sv
// Directed bench for vga_rx_tracker on a reduced 32x24 raster.
// Scenario tasks check lock, bbox, geometry errors and reset.
module tb_vga_rx_tracker;

  localparam int          H   = 32;
  localparam int          V   = 24;
  localparam int          HB  = 8;
  localparam logic [23:0] KEY = 24'hFF0000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vga_hs = 1'b1;
  logic       vga_vs = 1'b1;
  logic       vga_blank_n = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic [9:0] pix_x, pix_y;
  logic       locked, geom_err, frame_done, obj_found;
  logic [9:0] obj_x_min, obj_x_max, obj_y_min, obj_y_max;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int ge_cnt = 0;

  vga_rx_tracker #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .KEY_RGB(KEY), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .red(red), .green(green), .blue(blue),
    .pix_x(pix_x), .pix_y(pix_y),
    .locked(locked), .geom_err(geom_err),
    .frame_done(frame_done), .obj_found(obj_found),
    .obj_x_min(obj_x_min), .obj_x_max(obj_x_max),
    .obj_y_min(obj_y_min), .obj_y_max(obj_y_max)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (geom_err)   ge_cnt++;
  end

  task automatic drive(input logic hs, input logic vs,
                       input logic bl, input logic [23:0] rgb);
    vga_hs = hs;
    vga_vs = vs;
    vga_blank_n = bl;
    {red, green, blue} = rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y,
                       input int bx0, input int bx1,
                       input int by0, input int by1);
    logic [23:0] c;
    if (bx0 >= 0 && x >= bx0 && x <= bx1 && y >= by0 && y <= by1)
      c = KEY;
    else if (x == y)
      c = 24'hFF0001;
    else
      c = {8'(x), 8'(y), 8'h55};
    drive(1'b1, 1'b1, 1'b1, c);
  endtask

  task automatic hblank();
    for (int i = 0; i < HB; i++)
      drive(!(i >= 2 && i < 6), 1'b1, 1'b0, 24'h0);
  endtask

  task automatic send_line(input int y, input int len,
                           input int bx0, input int bx1,
                           input int by0, input int by1);
    for (int x = 0; x < len; x++)
      pixel(x, y, bx0, bx1, by0, by1);
    hblank();
  endtask

  task automatic blank_line(input logic vs);
    for (int i = 0; i < H + HB; i++)
      drive(!(i >= H + 2 && i < H + 6), vs, 1'b0, 24'h0);
  endtask

  task automatic send_vsync();
    blank_line(1'b1);
    blank_line(1'b0);
    blank_line(1'b1);
  endtask

  task automatic send_frame(input int nlines, input int short_y,
                            input int bx0, input int bx1,
                            input int by0, input int by1);
    for (int y = 0; y < nlines; y++)
      send_line(y, (y == short_y) ? H - 1 : H, bx0, bx1, by0, by1);
    send_vsync();
  endtask

  task automatic test_reset();
    logic [44:0] got;
    reset = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
    got = {pix_x, pix_y, locked, geom_err, frame_done, obj_found,
           obj_x_min, obj_x_max, obj_y_min, obj_y_max};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_lock();
    send_vsync();
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b0 || fd_cnt != 1) begin
      failures++;
      $display("FAIL lock_f1: locked=%0b fd=%0d want 0/1",
               locked, fd_cnt);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || fd_cnt != 2) begin
      failures++;
      $display("FAIL lock_f2: locked=%0b fd=%0d want 1/2",
               locked, fd_cnt);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || fd_cnt != 3 || ge_cnt != 0) begin
      failures++;
      $display("FAIL lock_f3: locked=%0b fd=%0d ge=%0d want 1/3/0",
               locked, fd_cnt, ge_cnt);
    end
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max}
        !== 41'h0) begin
      failures++;
      $display("FAIL lock_nobj: found=%0b box=%0d,%0d,%0d,%0d want 0",
               obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
    checks++;
    if (pix_x !== 10'(H - 1) || pix_y !== 10'(V - 1)) begin
      failures++;
      $display("FAIL pix_hold: got %0d,%0d want %0d,%0d",
               pix_x, pix_y, H - 1, V - 1);
    end
  endtask

  task automatic test_square();
    int fd0;
    fd0 = fd_cnt;
    send_frame(V, -1, 10, 13, 5, 7);
    checks++;
    if (fd_cnt != fd0 + 1) begin
      failures++;
      $display("FAIL sq_done: got %0d want %0d", fd_cnt, fd0 + 1);
    end
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max} !==
        {1'b1, 10'd10, 10'd13, 10'd5, 10'd7}) begin
      failures++;
      $display("FAIL sq_box: found=%0b box=%0d,%0d,%0d,%0d want 1 10,13,5,7",
               obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
  endtask

  task automatic test_single_pixel();
    send_frame(V, -1, H - 1, H - 1, V - 1, V - 1);
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max} !==
        {1'b1, 10'(H - 1), 10'(H - 1), 10'(V - 1), 10'(V - 1)}) begin
      failures++;
      $display("FAIL px_box: found=%0b box=%0d,%0d,%0d,%0d want 1 31,31,23,23",
               obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
  endtask

  task automatic test_short_line();
    int fd0, ge0;
    fd0 = fd_cnt;
    ge0 = ge_cnt;
    send_frame(V, 4, 0, 3, 0, 3);
    checks++;
    if (ge_cnt != ge0 + 1 || fd_cnt != fd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL short_err: ge=%0d fd=%0d locked=%0b want %0d/%0d/0",
               ge_cnt, fd_cnt, locked, ge0 + 1, fd0);
    end
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max} !==
        {1'b1, 10'(H - 1), 10'(H - 1), 10'(V - 1), 10'(V - 1)}) begin
      failures++;
      $display("FAIL short_hold: box=%0d,%0d,%0d,%0d want 31,31,23,23",
               obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b0 || fd_cnt != fd0 + 1) begin
      failures++;
      $display("FAIL relock_a: locked=%0b fd=%0d want 0/%0d",
               locked, fd_cnt, fd0 + 1);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || fd_cnt != fd0 + 2) begin
      failures++;
      $display("FAIL relock_b: locked=%0b fd=%0d want 1/%0d",
               locked, fd_cnt, fd0 + 2);
    end
  endtask

  task automatic test_mid_reset();
    int fd0, ge0;
    logic [44:0] got;
    for (int y = 0; y < 5; y++)
      send_line(y, H, -1, 0, 0, 0);
    for (int x = 0; x < 10; x++)
      pixel(x, 5, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || pix_y !== 10'd5) begin
      failures++;
      $display("FAIL pre_reset: locked=%0b y=%0d want 1/5", locked, pix_y);
    end
    reset = 1'b0;
    #1;
    got = {pix_x, pix_y, locked, geom_err, frame_done, obj_found,
           obj_x_min, obj_x_max, obj_y_min, obj_y_max};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %h want 0", got);
    end
    for (int x = 10; x < 13; x++)
      pixel(x, 5, -1, 0, 0, 0);
    reset = 1'b1;
    fd0 = fd_cnt;
    ge0 = ge_cnt;
    for (int x = 13; x < H; x++)
      pixel(x, 5, -1, 0, 0, 0);
    hblank();
    for (int y = 6; y < V; y++)
      send_line(y, H, -1, 0, 0, 0);
    send_vsync();
    checks++;
    if (locked !== 1'b0 || fd_cnt != fd0 || ge_cnt != ge0) begin
      failures++;
      $display("FAIL rst_partial: locked=%0b fd=%0d ge=%0d want 0/%0d/%0d",
               locked, fd_cnt, ge_cnt, fd0, ge0);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b0 || fd_cnt != fd0 + 1) begin
      failures++;
      $display("FAIL rst_f1: locked=%0b fd=%0d want 0/%0d",
               locked, fd_cnt, fd0 + 1);
    end
    send_frame(V, -1, -1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || fd_cnt != fd0 + 2 || obj_found !== 1'b0) begin
      failures++;
      $display("FAIL rst_f2: locked=%0b fd=%0d found=%0b want 1/%0d/0",
               locked, fd_cnt, obj_found, fd0 + 2);
    end
  endtask

  task automatic test_tall_frame();
    int fd0, ge0;
    send_frame(V, -1, 2, 6, 20, 22);
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max} !==
        {1'b1, 10'd2, 10'd6, 10'd20, 10'd22}) begin
      failures++;
      $display("FAIL tall_pre: box=%0d,%0d,%0d,%0d want 2,6,20,22",
               obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
    fd0 = fd_cnt;
    ge0 = ge_cnt;
    send_frame(V + 1, -1, 0, 0, 0, 0);
    checks++;
    if (ge_cnt != ge0 + 1 || fd_cnt != fd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL tall_err: ge=%0d fd=%0d locked=%0b want %0d/%0d/0",
               ge_cnt, fd_cnt, locked, ge0 + 1, fd0);
    end
    checks++;
    if ({obj_found, obj_x_min, obj_x_max, obj_y_min, obj_y_max} !==
        {1'b1, 10'd2, 10'd6, 10'd20, 10'd22}) begin
      failures++;
      $display("FAIL tall_hold: box=%0d,%0d,%0d,%0d want 2,6,20,22",
               obj_x_min, obj_x_max, obj_y_min, obj_y_max);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_square();
    test_single_pixel();
    test_short_line();
    test_mid_reset();
    test_tall_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
